// File: rtl/terrain_carver.sv
// rtl/terrain_carver.sv - carves a filled circle out of column-organised terrain RAM
// One read-modify-write per touched column, columns visited in ascending order.
module terrain_carver #(
    parameter int COLS = 640,
    parameter int ROWS = 512
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [9:0]      X,
    input  logic [9:0]      Y,
    input  logic [9:0]      radius,
    output logic            busy,
    output logic            done,
    output logic [9:0]      mem_addr,
    output logic            mem_rd,
    input  logic [ROWS-1:0] mem_rdata,
    output logic            mem_we,
    output logic [ROWS-1:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HGT,
        S_RD,
        S_WT,
        S_WR,
        S_DN
    } state_t;

    localparam logic [10:0] LAST_COL = 11'(COLS - 1);

    state_t          state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [9:0]      r_q, r_d;
    logic [9:0]      col_q, col_d;
    logic [9:0]      col_hi_q, col_hi_d;
    logic [9:0]      h_q, h_d;
    logic [ROWS-1:0] word_q, word_d;

    logic signed [10:0] col_lo_s;
    logic [10:0]        col_lo;
    logic [10:0]        col_sum;
    logic [10:0]        col_hi;
    logic signed [10:0] dx_s;
    logic [9:0]         dx;
    logic [20:0]        hh, dd, rr;
    logic               fits;
    logic signed [11:0] row_lo_s, row_hi_s;
    logic [ROWS-1:0]    clr_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            r_q      <= '0;
            col_q    <= '0;
            col_hi_q <= '0;
            h_q      <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            col_q    <= col_d;
            col_hi_q <= col_hi_d;
            h_q      <= h_d;
            word_q   <= word_d;
        end
    end

    // Column span of the request, clipped to the screen; lo > hi means fully off-screen
    always_comb begin
        col_lo_s = $signed({1'b0, X}) - $signed({1'b0, radius});
        col_lo   = col_lo_s[10] ? 11'd0 : col_lo_s;
        col_sum  = {1'b0, X} + {1'b0, radius};
        col_hi   = (col_sum > LAST_COL) ? LAST_COL : col_sum;
    end

    // Half-height search: largest h (counting down from r) inside the circle at this column
    always_comb begin
        dx_s = $signed({1'b0, col_q}) - $signed({1'b0, x_q});
        dx   = dx_s[10] ? 10'(-dx_s) : dx_s[9:0];
        hh   = 21'(h_q) * 21'(h_q);
        dd   = 21'(dx) * 21'(dx);
        rr   = 21'(r_q) * 21'(r_q);
        fits = (hh + dd) <= rr;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        r_d      = r_q;
        col_d    = col_q;
        col_hi_d = col_hi_q;
        h_d      = h_q;
        word_d   = word_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d = X;
                    y_d = Y;
                    r_d = radius;
                    if (col_lo > col_hi) begin
                        state_d = S_DN;
                    end else begin
                        col_d    = col_lo[9:0];
                        col_hi_d = col_hi[9:0];
                        h_d      = radius;
                        state_d  = S_HGT;
                    end
                end
            end
            S_HGT: begin
                if (fits) begin
                    state_d = S_RD;
                end else begin
                    h_d = h_q - 10'd1;
                end
            end
            S_RD: state_d = S_WT;
            S_WT: begin
                word_d  = mem_rdata;
                state_d = S_WR;
            end
            S_WR: begin
                if (col_q == col_hi_q) begin
                    state_d = S_DN;
                end else begin
                    col_d   = col_q + 10'd1;
                    h_d     = r_q;
                    state_d = S_HGT;
                end
            end
            S_DN:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Rows [Y-h, Y+h]; clipping falls out of only enumerating rows that exist
    always_comb begin
        row_lo_s = $signed({2'b00, y_q}) - $signed({2'b00, h_q});
        row_hi_s = $signed({2'b00, y_q}) + $signed({2'b00, h_q});
        clr_mask = '0;
        for (int y = 0; y < ROWS; y++) begin
            clr_mask[y] = (y >= int'(row_lo_s)) && (y <= int'(row_hi_s));
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DN);
        mem_rd    = (state_q == S_RD);
        mem_we    = (state_q == S_WR);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_RD || state_q == S_WR) begin
            mem_addr = col_q;
        end
        if (state_q == S_WR) begin
            mem_wdata = word_q & ~clr_mask;
        end
    end

endmodule

// File: tb/tb_terrain_carver.sv
// tb/tb_terrain_carver.sv - scoreboard bench for terrain_carver
module tb_terrain_carver;

    localparam int COLS = 640;
    localparam int ROWS = 512;

    logic            clk;
    logic            reset;
    logic            start;
    logic [9:0]      X, Y, radius;
    logic            busy, done;
    logic [9:0]      mem_addr;
    logic            mem_rd;
    logic [ROWS-1:0] mem_rdata;
    logic            mem_we;
    logic [ROWS-1:0] mem_wdata;

    terrain_carver #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .reset(reset), .start(start), .X(X), .Y(Y), .radius(radius),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              addr;
        logic [ROWS-1:0] data;
    } wr_t;

    logic [ROWS-1:0] ram [COLS];
    logic [ROWS-1:0] mdl [COLS];
    wr_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int rd_cnt   = 0;
    int we_cnt   = 0;
    int last_we_addr = -1;

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    endtask

    task automatic chk_word(input string nm, input logic [ROWS-1:0] act, input logic [ROWS-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", nm, act, exp);
    endtask

    // Synchronous RAM, read latency 1
    always @(posedge clk) begin
        if (mem_rd && mem_addr < COLS) mem_rdata <= ram[mem_addr];
        if (mem_we && mem_addr < COLS) ram[mem_addr] <= mem_wdata;
    end

    // Monitor: every write strobe consumes one scoreboard entry
    always @(negedge clk) begin
        if (mem_rd) rd_cnt++;
        if (mem_we) begin
            we_cnt++;
            last_we_addr = int'(mem_addr);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write addr=%0d", mem_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk_int("wr_addr", int'(mem_addr), e.addr);
                chk_word("wr_data", mem_wdata, e.data);
            end
        end
    end

    // Reference: integer half-height floor(sqrt(r^2 - dx^2)) per column, rows within h of Y cleared
    task automatic model_carve(input int x, input int y, input int r, input int max_cols,
                               output int exp_cyc, output int exp_n);
        int lo, hi, dx, h;
        wr_t w;
        lo = x - r; if (lo < 0) lo = 0;
        hi = x + r; if (hi > COLS - 1) hi = COLS - 1;
        exp_cyc = 1;
        exp_n   = 0;
        for (int c = lo; c <= hi; c++) begin
            dx = (c > x) ? c - x : x - c;
            h = 0;
            while ((h + 1) * (h + 1) <= r * r - dx * dx) h++;
            exp_cyc += (r - h + 1) + 3;
            if (exp_n < max_cols) begin
                w.addr = c;
                w.data = mdl[c];
                for (int yy = 0; yy < ROWS; yy++)
                    if (yy >= y - h && yy <= y + h) w.data[yy] = 1'b0;
                mdl[c] = w.data;
                exp_q.push_back(w);
                exp_n++;
            end
        end
    endtask

    function automatic int ram_diff();
        int n = 0;
        for (int c = 0; c < COLS; c++) if (ram[c] !== mdl[c]) n++;
        return n;
    endfunction

    task automatic set_col(input int c, input logic [ROWS-1:0] v);
        ram[c] = v;
        mdl[c] = v;
    endtask

    task automatic run_carve(input int x, input int y, input int r, input bit pulse);
        int exp_cyc, exp_n, cyc, rd0, we0;
        bit got;
        model_carve(x, y, r, 1 << 30, exp_cyc, exp_n);
        rd0 = rd_cnt;
        we0 = we_cnt;
        @(negedge clk);
        X = 10'(x); Y = 10'(y); radius = 10'(r); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        X = 10'($urandom); Y = 10'($urandom); radius = 10'($urandom);
        chk_int("busy_after_accept", int'(busy), 1);
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 8000) begin
            if (done) begin
                got = 1'b1;
            end else begin
                start = (pulse && cyc == 3) ? 1'b1 : 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        chk_int("done_cycle", got ? cyc : -1, exp_cyc);
        chk_int("dn_outputs", int'(mem_rd) + int'(mem_we) + int'(mem_addr) + int'(mem_wdata != '0), 0);
        @(posedge clk); #1;
        chk_int("busy_after_done", int'(busy), 0);
        chk_int("reads", rd_cnt - rd0, exp_n);
        chk_int("writes", we_cnt - we0, exp_n);
        chk_int("queue_drained", exp_q.size(), 0);
        chk_int("ram_vs_model", ram_diff(), 0);
    endtask

    logic [ROWS-1:0] ones, ex, pat;

    initial begin
        int ec, en, n, seen, base_we;
        ones = '1;
        pat  = {16{32'hAAAA_AAAA}};
        mem_rdata = '0;
        reset = 1'b0; start = 1'b0; X = '0; Y = '0; radius = '0;
        for (int c = 0; c < COLS; c++) begin
            logic [ROWS-1:0] w;
            for (int k = 0; k < ROWS / 32; k++) w[k*32 +: 32] = $urandom;
            set_col(c, w);
        end
        repeat (2) @(posedge clk);
        #1;
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        chk_int("reset_strobes", int'(mem_rd) + int'(mem_we), 0);
        chk_int("reset_addr", int'(mem_addr), 0);
        chk_word("reset_wdata", mem_wdata, '0);
        @(negedge clk) reset = 1'b1;

        // Single pixel
        set_col(100, ones);
        run_carve(100, 200, 0, 1'b0);
        ex = ones; ex[200] = 1'b0;
        chk_word("pixel_word", ram[100], ex);

        // Small circle
        for (int c = 7; c <= 13; c++) set_col(c, ones);
        run_carve(10, 20, 3, 1'b0);
        ex = ones; ex[20] = 1'b0;
        chk_word("small_col7", ram[7], ex);
        ex = ones; ex[23:17] = '0;
        chk_word("small_col10", ram[10], ex);

        // Edge clipping, top and bottom
        for (int c = 0; c <= 8; c++) set_col(c, ones);
        run_carve(2, 3, 5, 1'b0);
        ex = ones; ex[8:0] = '0;
        chk_word("clip_low_col2", ram[2], ex);
        chk_word("clip_col8_untouched", ram[8], ones);
        for (int c = 0; c <= 8; c++) set_col(c, ones);
        run_carve(2, 510, 5, 1'b0);
        ex = ones; ex[511:505] = '0;
        chk_word("clip_high_col2", ram[2], ex);

        // Off-screen and right edge
        run_carve(700, 50, 10, 1'b0);
        run_carve(635, 300, 10, 1'b0);
        chk_int("right_edge_last_addr", last_we_addr, COLS - 1);

        // Data preservation
        set_col(10, pat);
        run_carve(10, 20, 3, 1'b0);
        ex = pat; ex[23:17] = '0;
        chk_word("preserve_col10", ram[10], ex);

        // Start pulsed while busy
        run_carve(400, 250, 6, 1'b1);

        // Reset in WT of the third column
        base_we = we_cnt;
        model_carve(50, 100, 4, 2, ec, en);
        @(negedge clk);
        X = 10'd50; Y = 10'd100; radius = 10'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0; n = 0;
        while (seen < 3 && n < 500) begin
            @(negedge clk);
            if (mem_rd) seen++;
            n++;
        end
        chk_int("reset_reached_rd3", seen, 3);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk_int("midreset_busy", int'(busy), 0);
        chk_int("midreset_strobes", int'(mem_rd) + int'(mem_we) + int'(done), 0);
        chk_int("midreset_addr", int'(mem_addr), 0);
        chk_word("midreset_wdata", mem_wdata, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_int("midreset_writes", we_cnt - base_we, 2);
        chk_int("midreset_queue", exp_q.size(), 0);
        chk_int("midreset_ram", ram_diff(), 0);
        run_carve(300, 10, 0, 1'b0);

        // Randomized carves
        for (int i = 0; i < 12; i++)
            run_carve($urandom_range(0, 700), $urandom_range(0, 600), $urandom_range(0, 15), (i % 3) == 0);
        run_carve(320, 256, 40, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/terrain_carver.md
# terrain_carver

Terrain write-back engine: on an explosion/impact request it carves a filled circle out of the column-organised terrain RAM. Each RAM word is one screen column of ROWS bits, where bit y = 1 means solid. The carver read-modify-writes every column the circle touches, clearing the solid bits inside it. It is the writer for the same per-column terrain words that the collision and draw logic read back.

## Interface
- COLS, 640: number of terrain columns; valid column addresses are 0..COLS-1.
- ROWS, 512: bits per column word; valid row indices are 0..ROWS-1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  carve request; sampled only when busy=0.
- X  in  10  circle centre column, unsigned.
- Y  in  10  circle centre row, unsigned.
- radius  in  10  circle radius r, unsigned; r=0 carves a single pixel.
- busy  out  1  high from the cycle after start is accepted through the DN state.
- done  out  1  one-cycle pulse in the DN state.
- mem_addr  out  10  column address; equals the current column in RD and WR, 0 otherwise.
- mem_rd  out  1  read strobe, high in RD only.
- mem_rdata  in  ROWS  column word; valid exactly one cycle after mem_rd (synchronous RAM, latency 1).
- mem_we  out  1  write strobe, high in WR only.
- mem_wdata  out  ROWS  write data; 0 when mem_we=0.

## Operation
- Moore machine with states IDLE, HGT, RD, WT, WR, DN. All outputs decode from registered state and registers only.
- **IDLE:**
  - On start=1, latch X, Y and r.
  - col_lo = max(X-r, 0), computed signed with 11 bits.
  - col_hi = min(X+r, COLS-1), computed with 11 bits.
  - If col_lo > col_hi (circle entirely off-screen), go to DN.
  - Otherwise set col = col_lo, set h = r, and go to HGT.
- **HGT:**
  - dx = |col - X|.
  - Test one candidate per cycle: h*h + dx*dx <= r*r, using 21-bit unsigned arithmetic.
  - If the test passes, go to RD. If it fails, decrement h and stay in HGT.
  - Termination is guaranteed because dx <= r.
- **RD:** assert mem_rd with mem_addr = col. Go to WT.
- **WT:** capture mem_rdata into a ROWS-bit register. Go to WR.
- **WR:**
  - Assert mem_we with mem_addr = col.
  - mem_wdata = captured word with bits y cleared for all y in [Y-h, Y+h] ∩ [0, ROWS-1]. Bounds are computed signed with 12 bits; Y >= ROWS is legal and yields clipping.
  - All other bits pass through unchanged. Bits already 0 stay 0.
  - If col == col_hi, go to DN. Otherwise col += 1, h = r, and go to HGT.
- **DN:** done=1, busy=1. Go to IDLE.
- Columns are always written in strictly ascending address order, exactly one read and one write per column.
- start while busy=1 is ignored, not queued. X, Y and radius may change freely after acceptance.

## Timing
- Reset (reset=0), asynchronous:
  - state goes to IDLE.
  - busy, done, mem_rd and mem_we go to 0.
  - mem_addr and mem_wdata go to 0.
  - All internal registers are cleared.
- Reset mid-operation: a write in progress is dropped (mem_we falls immediately). Columns completed before reset stay carved. There is no resume; the first start after reset release is accepted normally.
- Start accepted at edge 0: busy=1 from cycle 1.
- Per-column cost is (r - h_final + 1) HGT cycles + 3 (RD, WT, WR).
- Off-screen circle: DN in cycle 1, so done=1 in cycle 1 and busy=0 in cycle 2.
- A new start may be accepted in the first IDLE cycle after DN.

## Test plan
- **Single pixel.** r=0, X=100, Y=200, column 100 all ones.
  - Expect one write to addr 100 equal to all ones with bit 200 = 0.
  - HGT cycle 1, RD 2, WT 3, WR 4, done=1 in cycle 5.
- **Small circle.** r=3, X=10, Y=20, all columns all ones.
  - Expect writes to addrs 7..13 in order.
  - Cleared bits: col 7 → bit 20; col 8 → bits 18..22; col 9 → bits 18..22; col 10 → bits 17..23; cols 11..13 mirror cols 9..7.
- **Edge clipping.** X=2, Y=3, r=5.
  - Expect columns 0..7 only.
  - col 2 clears bits 0..8 with no wrap into high bits.
  - Same test with Y=510: col 2 clears bits 505..511 only.
- **Off-screen and right edge.**
  - X=700, r=10: no mem_rd or mem_we at all; done=1 in cycle 1.
  - X=635, r=10: last write is addr 639.
- **Data preservation and busy handling.**
  - Column 10 preloaded with 0xAAAA… pattern, r=3, X=10, Y=20: only bits 17..23 are forced to 0; all other bits are unchanged.
  - Pulse start mid-carve: no effect, no extra writes.
- **Reset mid-carve.** Assert reset in the WT of the 3rd column.
  - Outputs go to 0 without waiting for a clock edge.
  - Only 2 columns are modified.
  - After release, a new start (r=0) completes normally in 5 cycles.
